decoder_pipe: RTL

DECODER_PIPE -- requirements
Module: decoder_pipe

---
 rtl/decoder_pipe_pkg.sv | 22 ++
 rtl/decoder_pipe_dec.sv | 26 ++
 rtl/decoder_pipe.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/decoder_pipe_pkg.sv
// Shared constants, fill-state encoding and parameter legality helper for decoder_pipe.
package decoder_pipe_pkg;

  // Width and ceiling of the out-of-range beat counter.
  localparam int OOR_CNT_W = 8;
  localparam logic [OOR_CNT_W-1:0] OOR_CNT_MAX = '1;

  // Occupancy of the two-entry buffer: nothing, output register only, or
  // output register plus skid register.
  typedef enum logic [1:0] {
    FILL_EMPTY = 2'd0,
    FILL_OUT   = 2'd1,
    FILL_BOTH  = 2'd2
  } fill_t;

  // True when the parameter set describes a buildable decoder.
  function automatic bit params_legal(input int aw, input int nout, input int hold);
    return (aw >= 1) && (aw <= 6) && (nout >= 1) && (nout <= (1 << aw)) &&
           ((hold == 0) || (hold == 1));
  endfunction

endpackage

// File: rtl/decoder_pipe_dec.sv
// Combinational address-to-one-hot decoder with out-of-range flag.
module onehot_dec #(
  parameter int AW   = 3,
  parameter int NOUT = 8
) (
  input  logic [AW-1:0]   addr,
  input  logic            en,
  output logic [NOUT-1:0] onehot,
  output logic            oor
);

  // NOUT never exceeds 2^AW, so one extra bit is enough to hold it.
  localparam logic [AW:0] NOUT_LIM = NOUT[AW:0];

  // Raise the bit matching the address; an address past the last output
  // leaves the vector empty and flags the beat instead.
  always_comb begin
    onehot = '0;
    oor    = 1'b0;
    for (int k = 0; k < NOUT; k++) begin
      onehot[k] = en && (addr == AW'(k));
    end
    oor = en && ({1'b0, addr} >= NOUT_LIM);
  end

endmodule

// File: rtl/decoder_pipe.sv
// Registered one-hot decoder with a valid/ready output register plus skid
// register, so in_ready never depends combinationally on out_ready.
module decoder_pipe
  import decoder_pipe_pkg::*;
#(
  parameter int AW   = 3,
  parameter int NOUT = 8,
  parameter int HOLD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AW-1:0]        in_addr,
  input  logic                 in_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NOUT-1:0]      out_onehot,
  output logic                 out_oor,
  output logic [OOR_CNT_W-1:0] oor_cnt
);

  if (!params_legal(AW, NOUT, HOLD)) begin : g_bad_params
    $error("decoder_pipe: illegal AW/NOUT/HOLD combination");
  end

  fill_t                 fill_q;
  fill_t                 fill_d;
  logic                  in_ready_q;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  load_out;
  logic                  load_skid;
  logic                  move_skid;
  logic [NOUT-1:0]       dec_onehot;
  logic                  dec_oor;
  logic [NOUT-1:0]       out_onehot_q;
  logic                  out_oor_q;
  logic [NOUT-1:0]       skid_onehot_q;
  logic                  skid_oor_q;
  logic [OOR_CNT_W-1:0]  oor_cnt_q;

  // Decode once, ahead of both buffer registers.
  onehot_dec #(
    .AW   (AW),
    .NOUT (NOUT)
  ) u_dec (
    .addr   (in_addr),
    .en     (in_en),
    .onehot (dec_onehot),
    .oor    (dec_oor)
  );

  assign out_valid = (fill_q != FILL_EMPTY);
  assign in_ready  = in_ready_q;
  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid && out_ready;
  assign oor_cnt   = oor_cnt_q;

  // Occupancy register; in_ready is registered from the next occupancy so it
  // is low during reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q     <= FILL_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      fill_q     <= fill_d;
      in_ready_q <= (fill_d != FILL_BOTH);
    end
  end

  // Decide where an accepted beat lands and how occupancy moves this cycle.
  always_comb begin
    fill_d    = fill_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (fill_q)
      FILL_EMPTY: begin
        if (in_xfer) begin
          load_out = 1'b1;
          fill_d   = FILL_OUT;
        end
      end
      FILL_OUT: begin
        if (in_xfer && out_xfer) begin
          load_out = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          fill_d    = FILL_BOTH;
        end else if (out_xfer) begin
          fill_d = FILL_EMPTY;
        end
      end
      FILL_BOTH: begin
        if (out_xfer) begin
          move_skid = 1'b1;
          fill_d    = FILL_OUT;
        end
      end
      default: begin
        fill_d = FILL_EMPTY;
      end
    endcase
  end

  // Data registers; the output register keeps its contents after a drain so
  // hold mode can keep showing the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_onehot_q  <= '0;
      out_oor_q     <= 1'b0;
      skid_onehot_q <= '0;
      skid_oor_q    <= 1'b0;
    end else begin
      if (load_out) begin
        out_onehot_q <= dec_onehot;
        out_oor_q    <= dec_oor;
      end else if (move_skid) begin
        out_onehot_q <= skid_onehot_q;
        out_oor_q    <= skid_oor_q;
      end
      if (load_skid) begin
        skid_onehot_q <= dec_onehot;
        skid_oor_q    <= dec_oor;
      end
    end
  end

  // Count accepted out-of-range beats, sticking at the counter ceiling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_cnt_q <= '0;
    end else if (in_xfer && dec_oor && (oor_cnt_q != OOR_CNT_MAX)) begin
      oor_cnt_q <= oor_cnt_q + OOR_CNT_W'(1);
    end
  end

  // Pulse mode blanks the outputs when idle; hold mode shows the last beat.
  always_comb begin
    out_onehot = out_onehot_q;
    out_oor    = out_oor_q;
    if (!out_valid && (HOLD == 0)) begin
      out_onehot = '0;
      out_oor    = 1'b0;
    end
  end

endmodule
